// File: rtl/lab3_response_checker.sv
// rtl/lab3_response_checker.sv - sweeps all eight {a,b,c} vectors into a Lab3 cell and checks x/y
// Each vector is held HOLD_CYCLES cycles; x/y are sampled on the last edge of the hold.
module lab3_response_checker #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [7:0] EXP_X       = 8'b1001_0110,
    parameter logic [7:0] EXP_Y       = 8'b1110_1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask,
    output logic [2:0] first_fail_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic [2:0] idx;
    logic       sample;
    logic       mismatch;
    logic [3:0] err_next;

    assign sample   = (state == ST_DRIVE) && (hold_cnt == HOLD_LAST);
    assign mismatch = (x != EXP_X[idx]) || (y != EXP_Y[idx]);
    assign err_next = err_count + {3'b000, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_DRIVE;
            ST_DRIVE: if (sample && idx == 3'd7) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {a, b, c}      <= 3'b000;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            fail_mask      <= 8'h00;
            first_fail_idx <= 3'd0;
            idx            <= 3'd0;
            hold_cnt       <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    {a, b, c} <= 3'b000;
                    if (start) begin
                        idx            <= 3'd0;
                        hold_cnt       <= 8'd0;
                        err_count      <= 4'd0;
                        fail_mask      <= 8'h00;
                        first_fail_idx <= 3'd0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (sample) begin
                        if (mismatch) begin
                            fail_mask[idx] <= 1'b1;
                            err_count      <= err_next;
                            if (err_count == 4'd0) first_fail_idx <= idx;
                        end
                        // The last vector's own mismatch must count toward pass.
                        if (idx == 3'd7) begin
                            pass <= (err_next == 4'd0);
                            busy <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            idx       <= idx + 3'd1;
                            hold_cnt  <= 8'd0;
                            {a, b, c} <= idx + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    done      <= 1'b0;
                    hold_cnt  <= 8'd0;
                    {a, b, c} <= 3'b000;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_response_checker.sv
// tb/tb_lab3_response_checker.sv - scoreboard bench for lab3_response_checker
module tb_lab3_response_checker;

    typedef struct {
        logic       pass;
        logic [3:0] err;
        logic [7:0] mask;
        logic [2:0] ffi;
        int         hold;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start1 = 1'b0;
    int   mode = 0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic a, b, c, x, y, busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;
    logic [2:0] first_fail_idx;

    logic a1, b1, c1, x1, y1, busy1, done1, pass1;
    logic [3:0] err_count1;
    logic [7:0] fail_mask1;
    logic [2:0] first_fail_idx1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Lab3 cell models: ideal full adder, optionally with a stuck output
    assign x  = (mode == 1) ? 1'b0 : (a ^ b ^ c);
    assign y  = (mode == 2) ? 1'b1 : ((a & b) | (a & c) | (b & c));
    assign x1 = a1 ^ b1 ^ c1;
    assign y1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

    lab3_response_checker #(.HOLD_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .x(x), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_fail_idx(first_fail_idx)
    );

    lab3_response_checker #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_mask(fail_mask1), .first_fail_idx(first_fail_idx1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic [3:0] e, input logic [7:0] m,
                                input logic [2:0] f, input int h, input int d);
        exp_t r;
        r.pass = p; r.err = e; r.mask = m; r.ffi = f; r.hold = h; r.done_cyc = d;
        return r;
    endfunction

    // Monitor for the HOLD_CYCLES=10 instance: stimulus stepping and results on done
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            int t0;
            t0 = q0[0].done_cyc - 8 * q0[0].hold;
            if (cyc >= t0 && cyc < q0[0].done_cyc) begin
                chk("busy0", busy, 1);
                chk("abc0", {a, b, c}, (cyc - t0) / q0[0].hold);
            end
        end
        if (done) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", done, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("done_cyc0", cyc, e.done_cyc);
                chk("pass0", pass, e.pass);
                chk("err_count0", err_count, e.err);
                chk("fail_mask0", fail_mask, e.mask);
                if (e.err != 0) chk("first_fail_idx0", first_fail_idx, e.ffi);
                chk("busy_at_done0", busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (q1.size() > 0) begin
            int t0;
            t0 = q1[0].done_cyc - 8;
            if (cyc >= t0 && cyc < q1[0].done_cyc) begin
                chk("busy1", busy1, 1);
                chk("abc1", {a1, b1, c1}, cyc - t0);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", done1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("done_cyc1", cyc, e.done_cyc);
                chk("pass1", pass1, e.pass);
                chk("err_count1", err_count1, e.err);
                chk("fail_mask1", fail_mask1, e.mask);
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, q0.size() + q1.size(), 0);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
    endtask

    // Pulse start for one edge; T is the edge that samples it
    task automatic sweep0(input int m, input exp_t e);
        mode = m;
        start = 1'b1;
        e.done_cyc = cyc + 1 + 80;
        q0.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("reset_outs0", {a, b, c, busy, done, pass, err_count, fail_mask, first_fail_idx}, 0);
        chk("reset_outs1", {a1, b1, c1, busy1, done1, pass1, err_count1, fail_mask1}, 0);
        rst = 1'b0;
        @(negedge clk);

        sweep0(0, mk(1'b1, 4'd0, 8'h00, 3'd0, 10, 0));
        wait_drain("drain_ideal");
        chk("hold_pass_ideal", pass, 1);

        sweep0(1, mk(1'b0, 4'd4, 8'h96, 3'd1, 10, 0));
        wait_drain("drain_x_stuck0");
        chk("hold_mask_x_stuck0", fail_mask, 8'h96);

        sweep0(2, mk(1'b0, 4'd4, 8'h17, 3'd0, 10, 0));
        wait_drain("drain_y_stuck1");
        chk("hold_ffi_y_stuck1", first_fail_idx, 0);

        // start held high: second sweep accepted only from the IDLE edge T+82
        mode = 0;
        start = 1'b1;
        t = cyc + 1;
        q0.push_back(mk(1'b1, 4'd0, 8'h00, 3'd0, 10, t + 80));
        q0.push_back(mk(1'b1, 4'd0, 8'h00, 3'd0, 10, t + 162));
        repeat (83) @(negedge clk);
        chk("held_start_second_sweep", busy, 1);
        start = 1'b0;
        wait_drain("drain_held_start");

        // reset sampled at edge T+35, during vector 3
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (34) @(negedge clk);
        chk("abc_before_abort", {a, b, c}, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {a, b, c, busy, done, pass, err_count, fail_mask, first_fail_idx}, 0);
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        sweep0(0, mk(1'b1, 4'd0, 8'h00, 3'd0, 10, 0));
        wait_drain("drain_after_abort");

        start1 = 1'b1;
        q1.push_back(mk(1'b1, 4'd0, 8'h00, 3'd0, 1, cyc + 1 + 8));
        @(negedge clk);
        start1 = 1'b0;
        wait_drain("drain_hold1");
        chk("hold1_busy_low", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lab3_response_checker.md
Name: lab3_response_checker

Overview:
- Self-test block that exercises the Lab3 logic cell (inputs a, b, c; outputs x, y) from the receiving side of its test interface.
- Sweeps all 8 input vectors in ascending order {a,b,c} = 000..111 and holds each vector for a programmable settle time.
- At the end of each hold it samples x and y and compares them against parameterised truth tables.
- Reports a pass/fail summary, a per-vector fail mask and the first failing index. Sits beside a Lab3 instance as an on-chip replacement for the bench sweep.

Parameters:
- HOLD_CYCLES, 10, clock cycles each vector is held before x/y are sampled; legal range 1..255.
- EXP_X, 8'b1001_0110, expected x; bit i is the expected x for vector index i = {a,b,c}. Default is the full-adder sum.
- EXP_Y, 8'b1110_1000, expected y; bit i is the expected y for vector i. Default is the full-adder carry.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- a  output  1  stimulus MSB to Lab3, registered
- b  output  1  stimulus middle bit to Lab3, registered
- c  output  1  stimulus LSB to Lab3, registered
- x  input  1  Lab3 response x
- y  input  1  Lab3 response y
- busy  output  1  high while vectors are being driven
- done  output  1  one-cycle pulse when the sweep completes
- pass  output  1  high when the last completed sweep had zero mismatches
- err_count  output  4  number of mismatching vectors in the current/last sweep, 0..8
- fail_mask  output  8  bit i set if vector i mismatched on x or y
- first_fail_idx  output  3  lowest failing vector index; meaningful only when err_count != 0

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - a, b, c, busy, done, pass = 0.
  - err_count = 0, fail_mask = 0, first_fail_idx = 0; vector index = 0; hold counter = 0.
  - Reset mid-sweep aborts immediately with the same values. No partial result is kept.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - a, b, c = 0; busy = 0.
  - start=1 sampled at edge T → DRIVE. At the same edge: index = 0, hold counter = 0, err_count = 0, fail_mask = 0, first_fail_idx = 0, pass = 0, busy = 1, {a,b,c} = 000.
- DRIVE:
  - The hold counter increments every cycle.
  - Vector i is driven from edge T+i*HOLD_CYCLES until edge T+(i+1)*HOLD_CYCLES.
  - Sample edge is the edge at which counter == HOLD_CYCLES-1. At this edge, x and y (the values present in the last hold cycle) are compared against EXP_X[i] and EXP_Y[i].
  - Mismatch on either output at the sample edge: fail_mask[i] <= 1; err_count <= err_count+1; if err_count was 0, first_fail_idx <= i.
  - Sample edge with i < 7: index <= i+1, counter <= 0, {a,b,c} <= i+1.
  - Sample edge with i == 7: go to DONE; pass <= (final err_count == 0), including any mismatch on vector 7; busy <= 0; done <= 1.
  - start is ignored in DRIVE.
- DONE:
  - Lasts exactly one cycle, then goes to IDLE with done <= 0 and {a,b,c} <= 000.
  - start in the DONE cycle is ignored; a new sweep needs start while in IDLE.
- Latency:
  - done rises at edge T+8*HOLD_CYCLES.
  - Total busy time is 8*HOLD_CYCLES cycles.
- Result holding: pass, err_count, fail_mask and first_fail_idx hold their values from DONE until the next accepted start or a reset.
- HOLD_CYCLES = 1: every cycle is a sample edge; vectors change every cycle; done at T+8.
- Widths: err_count saturates naturally, since at most 8 mismatches fit in 4 bits. The index does not wrap back to 0 inside a sweep.

Test Plan:
- Ideal full-adder model on x/y, HOLD_CYCLES=10, start pulse at edge T:
  - {a,b,c} steps 000→111 every 10 cycles.
  - done pulses at T+80.
  - pass=1, err_count=0, fail_mask=8'h00, busy low after T+80.
- x stuck at 0, y correct:
  - err_count=4, fail_mask=8'h96, first_fail_idx=1, pass=0.
- y stuck at 1, x correct:
  - mismatches at vectors 0, 1, 2, 4 → err_count=4, fail_mask=8'h17, first_fail_idx=0, pass=0.
- start held high throughout the sweep and through the DONE cycle:
  - exactly one sweep runs; done pulses once at T+80.
  - a second sweep starts only from the IDLE cycle after DONE.
- rst asserted at T+35 (during vector 3):
  - next cycle: all outputs 0 and state IDLE.
  - a fresh start then runs a full, correct sweep.
- HOLD_CYCLES=1 with ideal model:
  - vectors change every cycle; done at T+8; pass=1.
